simon_decifra: RTL

SIMON_DECIFRA -- requirements
Module: simon_decifra

---
 rtl/simon_decifra.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/simon_decifra.sv
// Simon128/128 decryption engine with an on-chip key schedule.
//
// A master key is taken over the key_valid/key_ready handshake. The block then
// expands it into ROUNDS 64-bit round keys, one per cycle, and keeps them for
// later blocks. Each ciphertext is taken over the in_valid/in_ready handshake.
// The block runs one inverse round per cycle, from k[ROUNDS-1] down to k[0].
// The plaintext is presented on out_valid/out_ready.
//
// Ports
//   clk        single clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   key_valid  master key offered
//   key_ready  block can accept a key (IDLE after the first edge, PRONTO)
//   key_i      master key: [63:0]=k0, [127:64]=k1
//   in_valid   ciphertext offered
//   in_ready   block can accept ciphertext (PRONTO and no key offered)
//   cifrado_i  ciphertext: [127:64]=x, [63:0]=y
//   out_valid  plaintext available
//   out_ready  consumer accepts plaintext
//   texto_o    plaintext: [127:64]=PT1, [63:0]=PT2; holds until the next result
module simon_decifra #(
    parameter int unsigned ROUNDS = 68
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_i,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cifrado_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] texto_o
);

    localparam int unsigned CW = 7;
    localparam int unsigned AW = $clog2(ROUNDS);
    localparam logic [63:0] KEY_CONST = 64'hFFFF_FFFF_FFFF_FFFC;
    // z2 sequence; index 0 is the leftmost bit, which is bit 61 here.
    localparam logic [61:0] Z2 =
        62'b10101111011100000011010010011000101000010001111110010110110011;

    typedef enum logic [2:0] {
        IDLE,
        EXPANDE,
        PRONTO,
        DECIFRA,
        SAIDA
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          in_rdy_q;
    logic [63:0]   st_x;
    logic [63:0]   st_y;
    logic [63:0]   rk [ROUNDS];

    logic          key_fire;
    logic          in_fire;
    logic [63:0]   ks_t;
    logic [5:0]    z_idx;
    logic          z_bit;
    logic [63:0]   next_key;
    logic [63:0]   round_key;
    logic [63:0]   next_y;

    // 64-bit rotations used by the round function and the key schedule
    function automatic logic [63:0] rol1(input logic [63:0] v);
        return {v[62:0], v[63]};
    endfunction

    function automatic logic [63:0] rol2(input logic [63:0] v);
        return {v[61:0], v[63:62]};
    endfunction

    function automatic logic [63:0] rol8(input logic [63:0] v);
        return {v[55:0], v[63:56]};
    endfunction

    function automatic logic [63:0] ror1(input logic [63:0] v);
        return {v[0], v[63:1]};
    endfunction

    function automatic logic [63:0] ror3(input logic [63:0] v);
        return {v[2:0], v[63:3]};
    endfunction

    function automatic logic [63:0] simon_f(input logic [63:0] v);
        return (rol1(v) & rol8(v)) ^ rol2(v);
    endfunction

    // A pending key always wins over a pending ciphertext in PRONTO.
    assign in_ready = in_rdy_q & ~key_valid;
    assign key_fire = key_valid & key_ready;
    assign in_fire  = in_valid & in_ready;

    // Key schedule step: cnt=i produces k[i+2] from k[i] and k[i+1].
    always_comb begin
        ks_t     = ror3(rk[AW'(cnt + CW'(1))]);
        z_idx    = (cnt >= CW'(62)) ? 6'(cnt - CW'(62)) : 6'(cnt);
        z_bit    = Z2[6'd61 - z_idx];
        next_key = KEY_CONST ^ {63'd0, z_bit} ^ rk[AW'(cnt)] ^ ks_t ^ ror1(ks_t);
    end

    // Inverse round: {x,y} -> {y, x ^ f(y) ^ k}, keys consumed last to first.
    always_comb begin
        round_key = rk[AW'(CW'(ROUNDS - 1) - cnt)];
        next_y    = st_x ^ simon_f(st_y) ^ round_key;
    end

    // Round-key storage; contents are meaningless until a key is expanded,
    // so no reset is needed.
    always_ff @(posedge clk) begin
        if (key_fire) begin
            rk[0] <= key_i[63:0];
            rk[1] <= key_i[127:64];
        end else if (state == EXPANDE) begin
            rk[AW'(cnt + CW'(2))] <= next_key;
        end
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            key_ready <= 1'b0;
            in_rdy_q  <= 1'b0;
            out_valid <= 1'b0;
            texto_o   <= '0;
            st_x      <= '0;
            st_y      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_rdy_q <= 1'b0;
                    if (key_fire) begin
                        cnt <= '0;
                        // With only two rounds the master key is the whole schedule.
                        if (ROUNDS > 2) begin
                            state     <= EXPANDE;
                            key_ready <= 1'b0;
                        end else begin
                            state     <= PRONTO;
                            key_ready <= 1'b1;
                            in_rdy_q  <= 1'b1;
                        end
                    end else begin
                        key_ready <= 1'b1;
                    end
                end

                EXPANDE: begin
                    if (cnt == CW'(ROUNDS - 3)) begin
                        state     <= PRONTO;
                        cnt       <= '0;
                        key_ready <= 1'b1;
                        in_rdy_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                PRONTO: begin
                    if (key_fire) begin
                        cnt <= '0;
                        if (ROUNDS > 2) begin
                            state     <= EXPANDE;
                            key_ready <= 1'b0;
                            in_rdy_q  <= 1'b0;
                        end
                    end else if (in_fire) begin
                        state     <= DECIFRA;
                        cnt       <= '0;
                        key_ready <= 1'b0;
                        in_rdy_q  <= 1'b0;
                        st_x      <= cifrado_i[127:64];
                        st_y      <= cifrado_i[63:0];
                    end
                end

                DECIFRA: begin
                    st_x <= st_y;
                    st_y <= next_y;
                    if (cnt == CW'(ROUNDS - 1)) begin
                        state     <= SAIDA;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        texto_o   <= {st_y, next_y};
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                SAIDA: begin
                    if (out_ready) begin
                        state     <= PRONTO;
                        out_valid <= 1'b0;
                        key_ready <= 1'b1;
                        in_rdy_q  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    key_ready <= 1'b0;
                    in_rdy_q  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
